// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine holding the HI/LO registers, with MTHI/MTLO writes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_n;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0] mag_b, raw_a, mag_a_n, mag_b_n, quot, rem;
  logic [WIDTH:0] madd, trial;
  logic [CW-1:0] cnt;
  logic is_div, sa, sb, sa_n, sb_n;
  assign busy = state != IDLE;
  // Signs are forced to zero for unsigned ops, so magnitudes equal raw values there.
  always_comb begin
    sa_n = ~op[0] & operand_a[WIDTH-1];
    sb_n = ~op[0] & operand_b[WIDTH-1];
    mag_a_n = sa_n ? -operand_a : operand_a;
    mag_b_n = sb_n ? -operand_b : operand_b;
    madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    prod = (sa ^ sb) ? -acc : acc;
    quot = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    state_n = (state == IDLE && start) ? CALC :
              (state == CALC && cnt == CW'(WIDTH-1)) ? FINISH :
              (state == FINISH) ? IDLE : state;
  end
  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      mag_b <= '0;
      raw_a <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      if (state == IDLE && start) begin
        acc <= {{WIDTH{1'b0}}, mag_a_n};
        mag_b <= mag_b_n;
        raw_a <= operand_a;
        sa <= sa_n;
        sb <= sb_n;
        is_div <= op[1];
        cnt <= '0;
      end else if (state == IDLE) begin
        if (mt_hi) hi <= operand_a;
        if (mt_lo) lo <= operand_a;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? {trial[WIDTH] ? acc[2*WIDTH-2:WIDTH-1] : trial[WIDTH-1:0], acc[WIDTH-2:0], ~trial[WIDTH]}
                      : {madd, acc[WIDTH-1:1]};
      end else begin
        done <= 1'b1;
        div_by_zero <= is_div && mag_b == '0;
        hi <= !is_div ? prod[2*WIDTH-1:WIDTH] : (mag_b == '0) ? raw_a : rem;
        lo <= !is_div ? prod[WIDTH-1:0] : (mag_b == '0) ? '1 : quot;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0, mt_hi = 0, mt_lo = 0;
  logic [1:0] op = 0;
  logic [W-1:0] operand_a = 0, operand_b = 0;
  logic busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  int compared = 0, mismatched = 0, cyc = 0;
  typedef struct {logic [W-1:0] hi, lo; logic dbz; int at;} exp_t;
  exp_t sb_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand_a(operand_a), .operand_b(operand_b),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dbz = 0;
    e.at = 0;
    if (o == 2'b00) p = 64'(sa * sb);
    else if (o == 2'b01) p = 64'(a) * 64'(b);
    else p = 0;
    e.hi = p[63:32];
    e.lo = p[31:0];
    if (o[1] && b == 0) begin
      e.dbz = 1;
      e.hi = a;
      e.lo = '1;
    end else if (o == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else if (o == 2'b11) begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation, including its timing.
  always @(negedge clk) begin
    if (!rst && div_by_zero && !done) begin
      mismatched++;
      $display("FAIL dbz_no_done: div_by_zero=1 without done at cycle %0d", cyc);
    end
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        compared++;
        if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz || cyc != e.at) begin
          mismatched++;
          $display("FAIL result: got hi=%h lo=%h dbz=%b cyc=%0d expected hi=%h lo=%h dbz=%b cyc=%0d",
                   hi, lo, div_by_zero, cyc, e.hi, e.lo, e.dbz, e.at);
        end
      end
    end
  end

  // Issue one op; optionally, intrude with start+mt_hi after 5 busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit intrude);
    exp_t e;
    int n;
    e = model(o, a, b);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1;
    @(posedge clk);
    #1;
    e.at = cyc + W + 1;
    sb_q.push_back(e);
    start = 0;
    n = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(negedge clk);
      if (done || !busy) break;
      n++;
      op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
      if (intrude && n == 5) begin
        start = 1; mt_hi = 1; operand_a = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 0; mt_hi = 0;
      end
    end
    check("busy_cycles", 32'(n), 32'(W + 1));
  endtask

  initial begin
    #12;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    @(negedge clk);
    rst = 0;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 0);
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 0);
    run_op(2'b11, 32'h00000064, 32'h00000007, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(2'b11, 32'h12345678, 32'h00000000, 0);
    run_op(2'b10, 32'h87654321, 32'h00000000, 0);
    run_op(2'b00, 32'h00001234, 32'hFFFF0001, 1);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(2'($urandom), a, b, 0);
    end
    // Reset mid-divide: outputs clear at once and no done ever follows.
    @(negedge clk);
    op = 2'b10; operand_a = 32'h7FFF0000; operand_b = 32'h00000003; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    check("midreset_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 0;
    repeat (2 * W) @(negedge clk);
    operand_a = 32'hA5A5A5A5; mt_lo = 1;
    @(posedge clk);
    #1;
    mt_lo = 0;
    check("mtlo_lo", lo, 32'hA5A5A5A5);
    check("mtlo_hi", hi, 0);
    check("mtlo_done", 32'(done), 0);
    @(negedge clk);
    operand_a = 32'h0BADF00D; mt_hi = 1; mt_lo = 1;
    @(posedge clk);
    #1;
    mt_hi = 0; mt_lo = 0;
    check("mtboth_hi", hi, 32'h0BADF00D);
    check("mtboth_lo", lo, 32'h0BADF00D);
    repeat (4) @(negedge clk);
    check("outstanding", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
